// File: rtl/window3x3_reducer.sv
// 3x3 window reducer: collects nine slot-tagged neighbour samples (zero for
// out-of-image slots), then reduces them to median, max, min or mean and
// presents the result on a ready/valid port.
// Optional feature macro: WIN_REDUCE_MEAN_EN enables the mean operation for
// op_sel=11; without it op_sel=11 selects the median.
module window3x3_reducer #(
   parameter int unsigned DW    = 8,
   parameter int unsigned IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       op_sel,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_idx,
   input  logic             in_eff,
   input  logic [DW-1:0]    in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_data,
   output logic             out_last,
   output logic             frame_done
);

   localparam int unsigned NSLOT    = 9;
   localparam int unsigned SEL_W    = 4;
   localparam int unsigned PASS_W   = 3;
   localparam int unsigned MED_LAST = 4;
   localparam logic [1:0]  OP_MED   = 2'b00;
   localparam logic [1:0]  OP_MAX   = 2'b01;
   localparam logic [1:0]  OP_MIN   = 2'b10;
   localparam logic [1:0]  OP_MEAN  = 2'b11;

   typedef enum logic [1:0] {S_COLLECT, S_CALC, S_HOLD} state_t;

   state_t              state_q, state_d;
   logic [DW-1:0]       slot_q [NSLOT];
   logic [DW-1:0]       slot_d [NSLOT];
   logic [NSLOT-1:0]    mask_q, mask_d;
   logic [PASS_W-1:0]   pass_q, pass_d;
   logic [1:0]          op_q, op_d;
   logic                last_q, last_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [DW-1:0]       out_data_q, out_data_d;
   logic                out_last_q, out_last_d;

   logic [DW-1:0]       max_val_c;
   logic [SEL_W-1:0]    max_idx_c;
   logic                max_found_c;
   logic [DW-1:0]       min_val_c;
   logic [1:0]          op_eff_c;
   logic                accept_c;

   assign accept_c = in_valid & in_ready_q & (state_q == S_COLLECT);

   // Operation captured with slot 8; mean folds to median when not built in
`ifdef WIN_REDUCE_MEAN_EN
   assign op_eff_c = op_sel;
`else
   assign op_eff_c = (op_sel == OP_MEAN) ? OP_MED : op_sel;
`endif

`ifdef WIN_REDUCE_MEAN_EN
   localparam int unsigned SUM_W = DW + 4;
   localparam int unsigned MUL_W = SUM_W + 13;
   logic [SUM_W-1:0] sum_c;
   logic [MUL_W-1:0] prod_c;
   logic [DW-1:0]    mean_c;

   // Window sum and divide-by-9 via reciprocal multiply
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < NSLOT; i++) sum_c = sum_c + SUM_W'(slot_q[i]);
   end
   assign prod_c = MUL_W'(sum_c) * MUL_W'(7282);
   assign mean_c = DW'(prod_c >> 16);
`endif

   // Max over unmasked slots (strict compare keeps lowest index on ties) and min over all
   always_comb begin
      max_val_c   = '0;
      max_idx_c   = '0;
      max_found_c = 1'b0;
      min_val_c   = slot_q[0];
      for (int i = 0; i < NSLOT; i++) begin
         if (!mask_q[i] && (!max_found_c || slot_q[i] > max_val_c)) begin
            max_val_c   = slot_q[i];
            max_idx_c   = SEL_W'(i);
            max_found_c = 1'b1;
         end
         if (slot_q[i] < min_val_c) min_val_c = slot_q[i];
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      mask_d      = mask_q;
      pass_d      = pass_q;
      op_d        = op_q;
      last_d      = last_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      case (state_q)
         S_COLLECT: begin
            if (accept_c) begin
               for (int i = 0; i < NSLOT; i++) begin
                  if (in_idx == IDX_W'(i)) slot_d[i] = in_eff ? in_data : '0;
               end
               if (in_idx == IDX_W'(NSLOT - 1)) begin
                  op_d    = op_eff_c;
                  last_d  = in_last;
                  pass_d  = '0;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            case (op_q)
               OP_MAX: begin
                  out_data_d  = max_val_c;
                  out_valid_d = 1'b1;
                  out_last_d  = last_q;
                  state_d     = S_HOLD;
               end
               OP_MIN: begin
                  out_data_d  = min_val_c;
                  out_valid_d = 1'b1;
                  out_last_d  = last_q;
                  state_d     = S_HOLD;
               end
`ifdef WIN_REDUCE_MEAN_EN
               OP_MEAN: begin
                  out_data_d  = mean_c;
                  out_valid_d = 1'b1;
                  out_last_d  = last_q;
                  state_d     = S_HOLD;
               end
`endif
               default: begin
                  for (int i = 0; i < NSLOT; i++) begin
                     if (max_idx_c == SEL_W'(i)) mask_d[i] = 1'b1;
                  end
                  pass_d = PASS_W'(pass_q + 1'b1);
                  if (pass_q == PASS_W'(MED_LAST)) begin
                     out_data_d  = max_val_c;
                     out_valid_d = 1'b1;
                     out_last_d  = last_q;
                     state_d     = S_HOLD;
                  end
               end
            endcase
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               mask_d      = '0;
               for (int i = 0; i < NSLOT; i++) slot_d[i] = '0;
               state_d     = S_COLLECT;
            end
         end
         default: state_d = S_COLLECT;
      endcase
   end

   assign in_ready_d = (state_d == S_COLLECT);

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_COLLECT;
         for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
         mask_q      <= '0;
         pass_q      <= '0;
         op_q        <= OP_MED;
         last_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         mask_q      <= mask_d;
         pass_q      <= pass_d;
         op_q        <= op_d;
         last_q      <= last_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   // Pulses in the handshake cycle of the frame's last result
   assign frame_done = (state_q == S_HOLD) & out_ready & out_last_q;

endmodule
